// File: rtl/nios_qsys_cpu_mulx_seq_if.sv
// Request/response bundle between the memory-stage pipeline and the
// sequential 32x32 multiply unit.
interface nios_qsys_cpu_mulx_seq_if;
  // Handshake: M_mulx_start is a request strobe that is taken only when the
  // unit is ready (busy low); a request seen while busy is dropped, not
  // queued. M_mulx_done pulses for one cycle with M_mulx_result valid in
  // that cycle. The result then holds until the next completion.
  logic        M_mulx_start;
  logic [1:0]  M_mulx_op;
  logic [31:0] M_mulx_src1;
  logic [31:0] M_mulx_src2;
  logic        M_mulx_busy;
  logic        M_mulx_done;
  logic [31:0] M_mulx_result;

  modport master (
    output M_mulx_start, M_mulx_op, M_mulx_src1, M_mulx_src2,
    input  M_mulx_busy, M_mulx_done, M_mulx_result
  );

  modport slave (
    input  M_mulx_start, M_mulx_op, M_mulx_src1, M_mulx_src2,
    output M_mulx_busy, M_mulx_done, M_mulx_result
  );
endinterface

// File: rtl/nios_qsys_cpu_mulx_seq.sv
// Sequential 32x32 multiply built from four passes through one registered
// 16x16 unsigned multiplier, with signed high-word correction at the end.
module nios_qsys_cpu_mulx_seq (
  input  logic                      clk,
  input  logic                      reset,
  nios_qsys_cpu_mulx_seq_if.slave   bus,
  output logic [2:0]                dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ISS0 = 3'd1,
    S_ISS1 = 3'd2,
    S_ISS2 = 3'd3,
    S_ISS3 = 3'd4,
    S_ACC  = 3'd5,
    S_FIX  = 3'd6,
    S_DONE = 3'd7
  } state_t;

  state_t      state;
  logic [31:0] src1_q;
  logic [31:0] src2_q;
  logic [1:0]  op_q;
  logic [31:0] mul_p;
  logic [63:0] acc;
  logic        busy_q;
  logic        done_q;
  logic [31:0] result_q;

  logic [15:0] mul_a;
  logic [15:0] mul_b;
  logic [31:0] prod;
  logic [63:0] addend;
  logic [63:0] sub_src1;
  logic [63:0] sub_src2;
  logic [63:0] acc_fixed;

  assign bus.M_mulx_busy   = busy_q;
  assign bus.M_mulx_done   = done_q;
  assign bus.M_mulx_result = result_q;
  assign dbg_state         = state;

  // Operand halves fed to the shared multiplier in each issue state.
  always_comb begin
    mul_a = 16'h0;
    mul_b = 16'h0;
    case (state)
      S_ISS0: begin mul_a = src1_q[15:0];  mul_b = src2_q[15:0];  end
      S_ISS1: begin mul_a = src1_q[31:16]; mul_b = src2_q[15:0];  end
      S_ISS2: begin mul_a = src1_q[15:0];  mul_b = src2_q[31:16]; end
      S_ISS3: begin mul_a = src1_q[31:16]; mul_b = src2_q[31:16]; end
      default: begin mul_a = 16'h0; mul_b = 16'h0; end
    endcase
  end

  assign prod = {16'h0, mul_a} * {16'h0, mul_b};

  // mul_p holds the product issued one state earlier, so its weight is
  // decided by the state that consumes it.
  always_comb begin
    addend = 64'h0;
    case (state)
      S_ISS1:         addend = {32'h0, mul_p};
      S_ISS2, S_ISS3: addend = {16'h0, mul_p, 16'h0};
      S_ACC:          addend = {mul_p, 32'h0};
      default:        addend = 64'h0;
    endcase
  end

  // Unsigned product minus 2^32*other operand for each negative signed input.
  assign sub_src1  = (op_q[1] && src1_q[31]) ? {src2_q, 32'h0} : 64'h0;
  assign sub_src2  = ((op_q == 2'b11) && src2_q[31]) ? {src1_q, 32'h0} : 64'h0;
  assign acc_fixed = acc - sub_src1 - sub_src2;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      src1_q   <= 32'h0;
      src2_q   <= 32'h0;
      op_q     <= 2'b00;
      mul_p    <= 32'h0;
      acc      <= 64'h0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 32'h0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.M_mulx_start) begin
            src1_q <= bus.M_mulx_src1;
            src2_q <= bus.M_mulx_src2;
            op_q   <= bus.M_mulx_op;
            acc    <= 64'h0;
            busy_q <= 1'b1;
            state  <= S_ISS0;
          end else begin
            state  <= S_IDLE;
          end
        end
        S_ISS0: begin
          mul_p <= prod;
          state <= S_ISS1;
        end
        S_ISS1: begin
          mul_p <= prod;
          acc   <= acc + addend;
          state <= S_ISS2;
        end
        S_ISS2: begin
          mul_p <= prod;
          acc   <= acc + addend;
          state <= S_ISS3;
        end
        S_ISS3: begin
          mul_p <= prod;
          acc   <= acc + addend;
          state <= S_ACC;
        end
        S_ACC: begin
          acc   <= acc + addend;
          state <= S_FIX;
        end
        S_FIX: begin
          acc      <= acc_fixed;
          result_q <= (op_q == 2'b00) ? acc_fixed[31:0] : acc_fixed[63:32];
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          state    <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nios_qsys_cpu_mulx_seq.sv
// Directed and randomized bench for the sequential multiply unit, checked
// against a plain-arithmetic 64-bit product model.
module tb_nios_qsys_cpu_mulx_seq;

  logic       clk;
  logic       reset;
  logic [2:0] dbg_state;
  int         checks;
  int         errors;

  nios_qsys_cpu_mulx_seq_if mif ();

  nios_qsys_cpu_mulx_seq dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (mif.slave),
    .dbg_state (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: full-width product of the extended operands.
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] p;
    case (op)
      2'b00, 2'b01: p = {32'h0, a} * {32'h0, b};
      2'b10:        p = $signed({{32{a[31]}}, a}) * $signed({32'h0, b});
      default:      p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    endcase
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Drivers. run() is entered just after a negedge and returns at the
  // negedge of the done cycle. mode 0: drop start after acceptance;
  // mode 1: also pulse start with junk operands mid-flight; mode 2: keep
  // start high with the next operation's operands through DONE.
  task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                     input int mode, input logic [1:0] op2, input logic [31:0] a2,
                     input logic [31:0] b2);
    logic [31:0] exp;
    exp = model(op, a, b);
    mif.M_mulx_start = 1'b1;
    mif.M_mulx_op    = op;
    mif.M_mulx_src1  = a;
    mif.M_mulx_src2  = b;
    for (int n = 1; n <= 7; n++) begin
      @(negedge clk);
      chk($sformatf("busy_c%0d", n), {31'h0, mif.M_mulx_busy}, {31'h0, (n <= 6)});
      chk($sformatf("done_c%0d", n), {31'h0, mif.M_mulx_done}, {31'h0, (n == 7)});
      if (n == 7)
        chk($sformatf("result_op%0d_%h_%h", op, a, b), mif.M_mulx_result, exp);
      if (mode == 2) begin
        mif.M_mulx_op   = op2;
        mif.M_mulx_src1 = a2;
        mif.M_mulx_src2 = b2;
      end else begin
        mif.M_mulx_start = (mode == 1) && (n == 3);
        mif.M_mulx_op    = 2'($urandom_range(0, 3));
        mif.M_mulx_src1  = $urandom;
        mif.M_mulx_src2  = $urandom;
      end
    end
  endtask

  task automatic idle(input int cycles, input logic [31:0] held);
    mif.M_mulx_start = 1'b0;
    for (int n = 0; n < cycles; n++) begin
      @(negedge clk);
      chk("idle_done", {31'h0, mif.M_mulx_done}, 32'h0);
      chk("idle_busy", {31'h0, mif.M_mulx_busy}, 32'h0);
      chk("idle_result_hold", mif.M_mulx_result, held);
    end
  endtask

  initial begin
    logic [1:0]  cur_op, nxt_op;
    logic [31:0] cur_a, cur_b, nxt_a, nxt_b;
    int          mode;
    logic        saw_done;

    checks = 0;
    errors = 0;
    reset = 1'b1;
    mif.M_mulx_start = 1'b0;
    mif.M_mulx_op    = 2'b00;
    mif.M_mulx_src1  = 32'h0;
    mif.M_mulx_src2  = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'h0, mif.M_mulx_busy}, 32'h0);
    chk("rst_done", {31'h0, mif.M_mulx_done}, 32'h0);
    chk("rst_result", mif.M_mulx_result, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Directed cases from the known-answer list
    run(2'b00, 32'h0001_2345, 32'h0000_0010, 0, 2'b00, 32'h0, 32'h0);
    chk("kat_mul", mif.M_mulx_result, 32'h0012_3450);
    idle(1, 32'h0012_3450);
    run(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 2'b00, 32'h0, 32'h0);
    chk("kat_mulxuu_ff", mif.M_mulx_result, 32'hFFFF_FFFE);
    idle(1, 32'hFFFF_FFFE);
    run(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 2'b00, 32'h0, 32'h0);
    chk("kat_mul_ff", mif.M_mulx_result, 32'h0000_0001);
    idle(1, 32'h0000_0001);
    run(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 2'b00, 32'h0, 32'h0);
    chk("kat_mulxss_ff", mif.M_mulx_result, 32'h0000_0000);
    idle(1, 32'h0000_0000);
    run(2'b11, 32'h8000_0000, 32'h8000_0000, 0, 2'b00, 32'h0, 32'h0);
    chk("kat_mulxss_min", mif.M_mulx_result, 32'h4000_0000);
    idle(1, 32'h4000_0000);
    run(2'b11, 32'h7FFF_FFFF, 32'h8000_0000, 0, 2'b00, 32'h0, 32'h0);
    chk("kat_mulxss_mix", mif.M_mulx_result, 32'hC000_0000);
    idle(1, 32'hC000_0000);
    run(2'b10, 32'hFFFF_FFFF, 32'h0000_0002, 0, 2'b00, 32'h0, 32'h0);
    chk("kat_mulxsu", mif.M_mulx_result, 32'hFFFF_FFFF);
    idle(1, 32'hFFFF_FFFF);
    run(2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 0, 2'b00, 32'h0, 32'h0);
    chk("kat_mulxuu_2", mif.M_mulx_result, 32'h0000_0001);
    idle(1, 32'h0000_0001);

    // Start pulsed while busy is ignored
    run(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 1, 2'b00, 32'h0, 32'h0);
    idle(2, model(2'b01, 32'h1234_5678, 32'h9ABC_DEF0));

    // Start held through DONE: second op accepted in the DONE cycle
    run(2'b11, 32'hDEAD_BEEF, 32'h0BAD_F00D, 2, 2'b10, 32'h8765_4321, 32'h0000_FFFF);
    run(2'b10, 32'h8765_4321, 32'h0000_FFFF, 0, 2'b00, 32'h0, 32'h0);
    idle(1, model(2'b10, 32'h8765_4321, 32'h0000_FFFF));

    // Randomized operations with mixed handshake patterns
    cur_op = 2'($urandom_range(0, 3));
    cur_a  = pick_operand();
    cur_b  = pick_operand();
    for (int i = 0; i < 40; i++) begin
      nxt_op = 2'($urandom_range(0, 3));
      nxt_a  = pick_operand();
      nxt_b  = pick_operand();
      mode   = $urandom_range(0, 2);
      run(cur_op, cur_a, cur_b, mode, nxt_op, nxt_a, nxt_b);
      if (mode != 2)
        idle($urandom_range(1, 2), model(cur_op, cur_a, cur_b));
      cur_op = nxt_op;
      cur_a  = nxt_a;
      cur_b  = nxt_b;
    end
    run(cur_op, cur_a, cur_b, 0, 2'b00, 32'h0, 32'h0);
    idle(1, model(cur_op, cur_a, cur_b));

    // Reset in ISS2 of a mulxss aborts with no done pulse
    mif.M_mulx_start = 1'b1;
    mif.M_mulx_op    = 2'b11;
    mif.M_mulx_src1  = 32'h8000_0000;
    mif.M_mulx_src2  = 32'h8000_0000;
    @(negedge clk);
    mif.M_mulx_start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", {31'h0, mif.M_mulx_busy}, 32'h0);
    chk("abort_done", {31'h0, mif.M_mulx_done}, 32'h0);
    chk("abort_result", mif.M_mulx_result, 32'h0);
    reset = 1'b0;
    saw_done = 1'b0;
    repeat (10) begin
      @(negedge clk);
      saw_done = saw_done | mif.M_mulx_done;
    end
    chk("abort_no_done", {31'h0, saw_done}, 32'h0);
    run(2'b01, 32'h0001_0000, 32'h0001_0000, 0, 2'b00, 32'h0, 32'h0);
    chk("post_reset_mulxuu", mif.M_mulx_result, 32'h0000_0001);
    idle(1, 32'h0000_0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
